// File: rtl/core_pkg.sv
// Shared types and widths for the RV32 core: datapath widths, ALU/forward/result encodings,
// and the ID/EX pipeline record.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Everything the execute stage keeps from decode; an all-zero record is a bubble.
  typedef struct packed {
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm_ext;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              alu_src;
    logic [1:0]        result_src;
    logic [2:0]        alu_control;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// 3:1 operand select for the execute stage: register value, WB result or MEM ALU result.
// The reserved select code falls back to the register value.
module fwd_mux
  import core_pkg::*;
(
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] reg_val,
  input  logic [XLEN-1:0] wb_val,
  input  logic [XLEN-1:0] mem_val,
  output logic [XLEN-1:0] out_val
);

  // Operand select
  always_comb begin
    out_val = reg_val;
    case (sel)
      FWD_WB:  out_val = wb_val;
      FWD_MEM: out_val = mem_val;
      default: out_val = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus execute-side operand forwarding and branch/jump resolution.
// Forwarding from MEM/WB is built only when IDEX_FORWARD_EN is defined.
module id_ex_stage
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ResultSrcD,
  input  logic [2:0]        ALUControlD,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              ZeroE,
  output logic [XLEN-1:0]   SrcAE,
  output logic [XLEN-1:0]   SrcBE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   WriteDataE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              PCSrcE
);

  id_ex_t            d_s;
  id_ex_t            ex_r;
  logic [1:0]        fwd_sel_a_s;
  logic [1:0]        fwd_sel_b_s;
  logic [XLEN-1:0]   fwd_wb_s;
  logic [XLEN-1:0]   fwd_mem_s;
  logic [XLEN-1:0]   fwd_a_s;
  logic [XLEN-1:0]   fwd_b_s;

  // Gather decode-side fields into one record
  always_comb begin
    d_s             = '0;
    d_s.rd1         = RD1D;
    d_s.rd2         = RD2D;
    d_s.pc          = PCD;
    d_s.pc_plus4    = PCPlus4D;
    d_s.imm_ext     = ImmExtD;
    d_s.rs1         = Rs1D;
    d_s.rs2         = Rs2D;
    d_s.rd          = RdD;
    d_s.reg_write   = RegWriteD;
    d_s.mem_write   = MemWriteD;
    d_s.jump        = JumpD;
    d_s.branch      = BranchD;
    d_s.alu_src     = ALUSrcD;
    d_s.result_src  = ResultSrcD;
    d_s.alu_control = ALUControlD;
  end

  // Pipeline register: reset and flush both load a bubble, and win over stall
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= '0;
    end else if (FlushE) begin
      ex_r <= '0;
    end else if (StallE) begin
      ex_r <= ex_r;
    end else begin
      ex_r <= d_s;
    end
  end

`ifdef IDEX_FORWARD_EN
  assign fwd_sel_a_s = ForwardAE;
  assign fwd_sel_b_s = ForwardBE;
  assign fwd_wb_s    = ResultW;
  assign fwd_mem_s   = ALUResultM;
`else
  // Without forwarding the hazard unit stalls on every RAW hazard, so the
  // forwarding inputs are deliberately left unconnected.
  logic unused_fwd_s;
  assign unused_fwd_s = &{1'b0, ForwardAE, ForwardBE, ALUResultM, ResultW};
  assign fwd_sel_a_s  = FWD_REG;
  assign fwd_sel_b_s  = FWD_REG;
  assign fwd_wb_s     = '0;
  assign fwd_mem_s    = '0;
`endif

  fwd_mux u_fwd_a (
    .sel     (fwd_sel_a_s),
    .reg_val (ex_r.rd1),
    .wb_val  (fwd_wb_s),
    .mem_val (fwd_mem_s),
    .out_val (fwd_a_s)
  );

  fwd_mux u_fwd_b (
    .sel     (fwd_sel_b_s),
    .reg_val (ex_r.rd2),
    .wb_val  (fwd_wb_s),
    .mem_val (fwd_mem_s),
    .out_val (fwd_b_s)
  );

  assign SrcAE       = fwd_a_s;
  assign WriteDataE  = fwd_b_s;
  assign SrcBE       = ex_r.alu_src ? ex_r.imm_ext : fwd_b_s;
  // Target wraps modulo 2^XLEN; carry out is dropped
  assign PCTargetE   = ex_r.pc + ex_r.imm_ext;
  assign PCSrcE      = ex_r.jump | (ex_r.branch & ZeroE);
  assign ALUControlE = ex_r.alu_control;
  assign PCPlus4E    = ex_r.pc_plus4;
  assign Rs1E        = ex_r.rs1;
  assign Rs2E        = ex_r.rs2;
  assign RdE         = ex_r.rd;
  assign RegWriteE   = ex_r.reg_write;
  assign MemWriteE   = ex_r.mem_write;
  assign ResultSrcE  = ex_r.result_src;

endmodule
